piso_tx_ctrl: RTL and testbench

Two-requester serializer controller built around a WIDTH-bit parallel-in/serial-out shift register. It arbitrates round-robin between two parallel-word sources and loads the winner's word into the shift register. It then shifts the word out MSB-first under a downstream ready/valid handshake and flags the first bit, the last bit and completion. It sits between word-level producers and a single-bit serial link, and replaces free-running PISO usage wherever the link is shared.

---
 rtl/piso_tx_ctrl.sv | 113 +++++++++++
 tb/tb_piso_tx_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx_ctrl.sv
// Two-requester round-robin arbiter feeding a WIDTH-bit MSB-first PISO shifter
// with a ready/valid serial output and first/last/done markers.
module piso_tx_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             s_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_first,
  output logic             s_last,
  output logic             owner,
  output logic             busy,
  output logic             done,
  output logic             dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic             r_owner;
  logic             r_last_owner;
  logic             r_done;
  logic             w_pick1;
  logic             w_load;
  logic             w_accept;
  logic             w_at_last;

  // Serial handshake: a bit transfers on any rising edge where s_valid and
  // s_ready are both high; s_out/s_first/s_last stay stable until it does.

  // On a tie the requester that did not win last time takes the grant.
  assign w_pick1   = req1 & (~req0 | ~r_last_owner);
  assign w_at_last = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_accept     = 1'b0;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Grants are gated by rst so nothing is granted while reset is held.
        if (rst && (req0 || req1)) begin
          w_load       = 1'b1;
          w_next_state = ST_SHIFT;
          gnt1         = w_pick1;
          gnt0         = ~w_pick1;
        end
      end
      ST_SHIFT: begin
        if (s_ready) begin
          w_accept = 1'b1;
          if (w_at_last) w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sreg       <= '0;
      r_cnt        <= '0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_accept & w_at_last;
      if (w_load) begin
        r_sreg       <= w_pick1 ? data1 : data0;
        r_owner      <= w_pick1;
        r_last_owner <= w_pick1;
        r_cnt        <= '0;
      end else if (w_accept) begin
        r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
        if (!w_at_last) r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign s_valid   = (r_state == ST_SHIFT);
  assign s_out     = s_valid & r_sreg[WIDTH-1];
  assign s_first   = s_valid & (r_cnt == '0);
  assign s_last    = s_valid & w_at_last;
  assign owner     = s_valid & r_owner;
  assign busy      = s_valid;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl: reset, single word, tie arbitration,
// backpressure, mid-word reset abort and single-requester streaming.
module tb_piso_tx_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         req0;
  logic         req1;
  logic [W-1:0] data0;
  logic [W-1:0] data1;
  logic         s_ready;
  logic         gnt0;
  logic         gnt1;
  logic         s_out;
  logic         s_valid;
  logic         s_first;
  logic         s_last;
  logic         owner;
  logic         busy;
  logic         done;
  logic         dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  piso_tx_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .data0    (data0),
    .data1    (data1),
    .s_ready  (s_ready),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .s_out    (s_out),
    .s_valid  (s_valid),
    .s_first  (s_first),
    .s_last   (s_last),
    .owner    (owner),
    .busy     (busy),
    .done     (done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {gnt0, gnt1, s_valid, s_out, s_first, s_last, owner, busy, done}
  logic [8:0] w_obs;
  assign w_obs = {gnt0, gnt1, s_valid, s_out, s_first, s_last, owner, busy, done};

  function automatic logic [8:0] ev(input logic g0, input logic g1, input logic v,
                                    input logic o, input logic f, input logic l,
                                    input logic own, input logic b, input logic d);
    return {g0, g1, v, o, f, l, own, b, d};
  endfunction

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [8:0] expv);
    #1;
    checks++;
    assert (w_obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (g0 g1 v o f l own busy done)", tag, w_obs, expv);
    end
  endtask

  // Shift out one word with s_ready high, scoreboarding each bit from exp_q.
  task automatic expect_word(input string tag, input logic own, input logic [W-1:0] w,
                             input logic clr0, input logic clr1);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) exp_q.push_back({{(W-1){1'b0}}, w[W-1-i]});
    for (int i = 0; i < W; i++) begin
      next_cycle();
      if (i == 0) begin
        if (clr0) req0 = 1'b0;
        if (clr1) req1 = 1'b0;
      end
      b = exp_q.pop_front();
      check($sformatf("%s_bit%0d", tag, i),
            ev(1'b0, 1'b0, 1'b1, b[0], i == 0, i == W - 1, own, 1'b1, 1'b0));
    end
  endtask

  initial begin
    rst     = 1'b0;
    req0    = 1'b1;
    req1    = 1'b0;
    data0   = 4'b1010;
    data1   = 4'b0000;
    s_ready = 1'b1;

    // Reset held with a pending request: everything reads zero.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check($sformatf("rst_hold%0d", i), 9'b0);
    end

    // Release mid-cycle: gnt0 in the first cycle after release, then 1010.
    rst = 1'b1;
    check("single_gnt", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    expect_word("single", 1'b0, 4'b1010, 1'b1, 1'b0);
    next_cycle();
    check("single_done", ev(0, 0, 0, 0, 0, 0, 0, 0, 1));
    next_cycle();
    check("single_idle", 9'b0);

    // Tie after reset: req0 first, then req1 granted in the done cycle.
    rst = 1'b0;
    check("tie_rst", 9'b0);
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 4'b1100;
    data1 = 4'b0011;
    next_cycle();
    check("tie_rst_hold", 9'b0);
    rst = 1'b1;
    check("tie_gnt0", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    expect_word("tie_w0", 1'b0, 4'b1100, 1'b1, 1'b0);
    next_cycle();
    check("tie_done_gnt1", ev(0, 1, 0, 0, 0, 0, 0, 0, 1));
    expect_word("tie_w1", 1'b1, 4'b0011, 1'b0, 1'b1);
    next_cycle();
    check("tie_done1", ev(0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Backpressure: two stall cycles on the second bit of 1001.
    next_cycle();
    req0  = 1'b1;
    data0 = 4'b1001;
    check("bp_gnt0", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    req0 = 1'b0;
    check("bp_bit0", ev(0, 0, 1, 1, 1, 0, 0, 1, 0));
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      s_ready = 1'b0;
      check($sformatf("bp_stall%0d", i), ev(0, 0, 1, 0, 0, 0, 0, 1, 0));
    end
    next_cycle();
    s_ready = 1'b1;
    check("bp_bit1", ev(0, 0, 1, 0, 0, 0, 0, 1, 0));
    next_cycle();
    check("bp_bit2", ev(0, 0, 1, 0, 0, 0, 0, 1, 0));
    next_cycle();
    check("bp_bit3", ev(0, 0, 1, 1, 0, 1, 0, 1, 0));
    next_cycle();
    check("bp_done", ev(0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Abort: reset on the third bit of 0110 with req1 held.
    next_cycle();
    req1  = 1'b1;
    data1 = 4'b0110;
    check("ab_gnt1", ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    check("ab_bit0", ev(0, 0, 1, 0, 1, 0, 1, 1, 0));
    next_cycle();
    check("ab_bit1", ev(0, 0, 1, 1, 0, 0, 1, 1, 0));
    next_cycle();
    check("ab_bit2", ev(0, 0, 1, 1, 0, 0, 1, 1, 0));
    rst = 1'b0;
    check("ab_rst_now", 9'b0);
    next_cycle();
    check("ab_rst_hold", 9'b0);
    rst = 1'b1;
    check("ab_regnt1", ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
    expect_word("ab_retx", 1'b1, 4'b0110, 1'b0, 1'b1);
    next_cycle();
    check("ab_done", ev(0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Streaming: req1 held, a new grant lands in every done cycle.
    next_cycle();
    req1  = 1'b1;
    data1 = 4'b1111;
    check("st_gnt_first", ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      expect_word($sformatf("st_w%0d", k), 1'b1, 4'b1111, 1'b0, k == 2);
      next_cycle();
      if (k < 2) check($sformatf("st_done_gnt%0d", k), ev(0, 1, 0, 0, 0, 0, 0, 0, 1));
      else       check("st_done_last", ev(0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    next_cycle();
    check("st_idle", 9'b0);

    // final report
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
